// File: rtl/ifft_8_iter.sv
// 8-point radix-2 DIT inverse FFT, one butterfly per clock, Q1.15 in/out.
// Each stage halves its outputs, so the frame leaves scaled by 1/8 (true IDFT).
module ifft_8_iter #(
  parameter int unsigned             WIDTH = 16,
  parameter logic signed [WIDTH-1:0] TW_C  = 16'sh5A82
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in_real  [7:0],
  input  logic [WIDTH-1:0] data_in_imag  [7:0],
  output logic [WIDTH-1:0] data_out_real [7:0],
  output logic [WIDTH-1:0] data_out_imag [7:0],
  output logic             done,
  output logic             busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned AW = 2 * WIDTH + 1;
  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [AW-1:0]    RND   = {{(AW-WIDTH+1){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_w_re [8];
  logic signed [WIDTH-1:0] r_w_im [8];
  logic [1:0]              r_stage;
  logic [1:0]              r_bfly;

  logic [2:0]              w_a_idx, w_b_idx;
  logic [1:0]              w_k;
  logic signed [WIDTH-1:0] w_a_re, w_a_im, w_b_re, w_b_im, w_nb_im;
  logic signed [PW-1:0]    w_p_re, w_p_im;
  logic signed [AW-1:0]    w_acc_re, w_acc_im;
  logic signed [WIDTH-1:0] w_t_re, w_t_im;
  logic signed [WIDTH:0]   w_sum_re, w_sum_im, w_dif_re, w_dif_im;

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  // Round-half-up Q(2W) -> Q(W) with saturation.
  function automatic logic signed [WIDTH-1:0] sat_round(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] r;
    r = (acc + RND) >>> (WIDTH - 1);
    if (r[AW-1:WIDTH-1] == {(AW-WIDTH+1){1'b0}} || r[AW-1:WIDTH-1] == {(AW-WIDTH+1){1'b1}})
      return r[WIDTH-1:0];
    return r[AW-1] ? S_MIN : S_MAX;
  endfunction

  // Butterfly pair (a, a+2^stage) and twiddle index for the current step.
  always_comb begin
    w_a_idx = 3'd0;
    w_b_idx = 3'd0;
    w_k     = 2'd0;
    case (r_stage)
      2'd0: begin
        w_a_idx = {r_bfly, 1'b0};
        w_b_idx = {r_bfly, 1'b1};
      end
      2'd1: begin
        w_a_idx = {r_bfly[1], 1'b0, r_bfly[0]};
        w_b_idx = {r_bfly[1], 1'b1, r_bfly[0]};
        w_k     = {r_bfly[0], 1'b0};
      end
      2'd2: begin
        w_a_idx = {1'b0, r_bfly};
        w_b_idx = {1'b1, r_bfly};
        w_k     = r_bfly;
      end
      default: ;
    endcase
  end

  assign w_a_re  = r_w_re[w_a_idx];
  assign w_a_im  = r_w_im[w_a_idx];
  assign w_b_re  = r_w_re[w_b_idx];
  assign w_b_im  = r_w_im[w_b_idx];
  assign w_nb_im = (w_b_im == S_MIN) ? S_MAX : -w_b_im;
  assign w_p_re  = PW'(w_b_re) * PW'(TW_C);
  assign w_p_im  = PW'(w_b_im) * PW'(TW_C);

  // t = W^k * b with W = e^{+j*pi/4}
  always_comb begin
    w_acc_re = '0;
    w_acc_im = '0;
    w_t_re   = w_b_re;
    w_t_im   = w_b_im;
    case (w_k)
      2'd1: begin
        w_acc_re = AW'(w_p_re) - AW'(w_p_im);
        w_acc_im = AW'(w_p_re) + AW'(w_p_im);
        w_t_re   = sat_round(w_acc_re);
        w_t_im   = sat_round(w_acc_im);
      end
      2'd2: begin
        w_t_re = w_nb_im;
        w_t_im = w_b_re;
      end
      2'd3: begin
        w_acc_re = -AW'(w_p_re) - AW'(w_p_im);
        w_acc_im = AW'(w_p_re) - AW'(w_p_im);
        w_t_re   = sat_round(w_acc_re);
        w_t_im   = sat_round(w_acc_im);
      end
      default: ;
    endcase
  end

  assign w_sum_re = (WIDTH+1)'(w_a_re) + (WIDTH+1)'(w_t_re);
  assign w_sum_im = (WIDTH+1)'(w_a_im) + (WIDTH+1)'(w_t_im);
  assign w_dif_re = (WIDTH+1)'(w_a_re) - (WIDTH+1)'(w_t_re);
  assign w_dif_im = (WIDTH+1)'(w_a_im) - (WIDTH+1)'(w_t_im);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_stage <= 2'd0;
      r_bfly  <= 2'd0;
      done    <= 1'b0;
      busy    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_w_re[i]        <= '0;
        r_w_im[i]        <= '0;
        data_out_real[i] <= '0;
        data_out_imag[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < 8; i++) begin
              r_w_re[i] <= data_in_real[bitrev3(3'(i))];
              r_w_im[i] <= data_in_imag[bitrev3(3'(i))];
            end
            r_stage <= 2'd0;
            r_bfly  <= 2'd0;
            busy    <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          // stage 3 means all 12 butterflies are done: publish the frame
          if (r_stage == 2'd3) begin
            for (int i = 0; i < 8; i++) begin
              data_out_real[i] <= r_w_re[i];
              data_out_imag[i] <= r_w_im[i];
            end
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_w_re[w_a_idx] <= WIDTH'(w_sum_re >>> 1);
            r_w_im[w_a_idx] <= WIDTH'(w_sum_im >>> 1);
            r_w_re[w_b_idx] <= WIDTH'(w_dif_re >>> 1);
            r_w_im[w_b_idx] <= WIDTH'(w_dif_im >>> 1);
            r_bfly          <= r_bfly + 2'd1;
            if (r_bfly == 2'd3) r_stage <= r_stage + 2'd1;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_stage <= 2'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
